// File: rtl/ws2812_frame_serializer.sv
// rtl/ws2812_frame_serializer.sv - WS2812 NRZ serializer: snapshot a GRB frame, shift it out, hold the latch gap, repeat.
module ws2812_frame_serializer #(
  parameter int NUM_LEDS     = 64,
  parameter int SYS_FREQ_MHZ = 100,
  parameter int PERIOD_NS    = 1250,
  parameter int T0H_NS       = 400,
  parameter int T1H_NS       = 800,
  parameter int RESET_US     = 80
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_LEDS*24-1:0] bits,
  output logic                   signal,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PERIOD_CYC = PERIOD_NS * SYS_FREQ_MHZ / 1000;
  localparam int T0H_CYC    = T0H_NS * SYS_FREQ_MHZ / 1000;
  localparam int T1H_CYC    = T1H_NS * SYS_FREQ_MHZ / 1000;
  localparam int RESET_CYC  = RESET_US * SYS_FREQ_MHZ;
  localparam int TOTAL_BITS = NUM_LEDS * 24;

  localparam int CW = $clog2(RESET_CYC) + 1;
  localparam int BW = $clog2(TOTAL_BITS) + 1;
  localparam int PW = $clog2(PERIOD_CYC) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL_BITS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] T0H      = PW'(T0H_CYC);
  localparam logic [PW-1:0] T1H      = PW'(T1H_CYC);

  if ((PERIOD_NS * SYS_FREQ_MHZ) % 1000 != 0 || (T0H_NS * SYS_FREQ_MHZ) % 1000 != 0 ||
      (T1H_NS * SYS_FREQ_MHZ) % 1000 != 0 ||
      !(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < PERIOD_CYC)) begin : g_bad_timing
    $error("ws2812_frame_serializer: derived bit timing must be integral with 0 < T0H < T1H < PERIOD");
  end

  typedef enum logic {LATCH, SEND} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [BW-1:0]           bit_idx, bit_idx_n;
  logic [PW-1:0]           phase, phase_n;
  logic [TOTAL_BITS-1:0]   shadow, shadow_n, ordered;
  logic [PW-1:0]           th;
  logic                    signal_n, busy_n, done_n;

  // Reorder so the shadow MSB is always the next bit on the wire (LED0 bit 23 first).
  always_comb begin
    ordered = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      ordered[(NUM_LEDS-1-k)*24 +: 24] = bits[k*24 +: 24];
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    phase_n   = phase;
    shadow_n  = shadow;
    done_n    = 1'b0;
    case (state)
      LATCH: begin
        if (cnt == CNT_LAST) begin
          state_n   = SEND;
          cnt_n     = '0;
          shadow_n  = ordered;
          bit_idx_n = '0;
          phase_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SEND: begin
        if (phase == PH_LAST) begin
          phase_n  = '0;
          shadow_n = {shadow[TOTAL_BITS-2:0], 1'b0};
          if (bit_idx == BIT_LAST) begin
            state_n   = LATCH;
            cnt_n     = '0;
            bit_idx_n = '0;
            done_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + BW'(1);
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: state_n = LATCH;
    endcase
    // Outputs are registered, so they are derived from the upcoming state.
    th       = shadow_n[TOTAL_BITS-1] ? T1H : T0H;
    busy_n   = (state_n == SEND);
    signal_n = busy_n && (phase_n < th);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LATCH;
      cnt        <= '0;
      bit_idx    <= '0;
      phase      <= '0;
      signal     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      phase      <= phase_n;
      signal     <= signal_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    shadow <= shadow_n;
  end

endmodule
